doodle_motion: RTL

//  Per-frame motion engine for the player sprite. Produces BallX/BallY/Ball_size
//  and outstate for the colour mapper directly downstream, which draws the sprite

---
 rtl/doodle_motion.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/doodle_motion.sv
// doodle_motion: per-frame motion engine for the player sprite.
// Applies gravity, platform bounces, left/right steering with screen wrap
// and the IDLE/RISE/FALL/DEAD game-state machine. Every state update
// happens once per frame_clk rising edge, on a single Clk cycle.
//
// Ports:
//   Clk        system clock
//   Reset      asynchronous active-low reset
//   frame_clk  frame strobe, asynchronous to Clk
//   keycode    current keycode (0x04 left, 0x07 right, 0x2C space, 0x28 enter)
//   plat_hit   sprite bottom overlaps a platform this frame
//   BallX      sprite centre X
//   BallY      sprite centre Y
//   Ball_size  sprite half-size (constant)
//   outstate   0=IDLE 1=RISE 2=FALL 3=DEAD
//   Bounces    platform bounce count, saturating at 255
`timescale 1ns/100ps
module doodle_motion #(
   parameter int X_START  = 320,
   parameter int Y_START  = 400,
   parameter int X_MAX    = 639,
   parameter int Y_MAX    = 479,
   parameter int SIZE     = 4,
   parameter int JUMP_V   = 12,
   parameter int GRAVITY  = 1,
   parameter int MAX_FALL = 12,
   parameter int X_STEP   = 2
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       frame_clk,
   input  logic [7:0] keycode,
   input  logic       plat_hit,
   output logic [9:0] BallX,
   output logic [9:0] BallY,
   output logic [9:0] Ball_size,
   output logic [2:0] outstate,
   output logic [7:0] Bounces
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_RISE = 3'd1;
   localparam logic [2:0] ST_FALL = 3'd2;
   localparam logic [2:0] ST_DEAD = 3'd3;

   localparam logic [7:0] KEY_A     = 8'h04;
   localparam logic [7:0] KEY_D     = 8'h07;
   localparam logic [7:0] KEY_SPACE = 8'h2C;
   localparam logic [7:0] KEY_ENTER = 8'h28;

   localparam logic signed [10:0] SIZE_W   = 11'(SIZE);
   localparam logic signed [10:0] X_LIM_W  = 11'(X_MAX - SIZE);
   localparam logic signed [10:0] Y_MAX_W  = 11'(Y_MAX);
   localparam logic signed [10:0] X_STEP_W = 11'(X_STEP);
   localparam logic signed [8:0]  GRAV_W   = 9'(GRAVITY);
   localparam logic signed [8:0]  MAXF_W   = 9'(MAX_FALL);
   localparam logic signed [7:0]  VY_LAUNCH = 8'(-JUMP_V);

   localparam logic [9:0] X_START_U = 10'(X_START);
   localparam logic [9:0] Y_START_U = 10'(Y_START);
   localparam logic [9:0] SIZE_U    = 10'(SIZE);
   localparam logic [9:0] X_WRAP_HI = 10'(X_MAX - SIZE);
   localparam logic [9:0] Y_REST_U  = 10'(Y_MAX - SIZE);

   logic                f1_r, f2_r, f3_r;
   logic                tick_s;
   logic [2:0]          state_r, state_nx_s;
   logic [9:0]          x_r, y_r, x_nx_s, y_nx_s;
   logic signed [7:0]   vy_r, vy_nx_s, vy_grav_s;
   logic [7:0]          bounces_r, bounces_nx_s;
   logic signed [10:0]  ny_s, nx_s;
   logic signed [8:0]   vy_sum_s;
   logic [9:0]          x_wrap_s;
   logic                ceil_s, bounce_s, floor_s;

   // Frame strobe synchroniser; tick marks the first Clk cycle after a rising edge.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         f1_r <= 1'b0;
         f2_r <= 1'b0;
         f3_r <= 1'b0;
      end else begin
         f1_r <= frame_clk;
         f2_r <= f1_r;
         f3_r <= f2_r;
      end
   end

   assign tick_s = f2_r & ~f3_r;

   // Physics arithmetic: vertical step, gravity with terminal speed, steering and wrap.
   always_comb begin
      ny_s     = $signed({1'b0, y_r}) + $signed({{3{vy_r[7]}}, vy_r});
      vy_sum_s = $signed({vy_r[7], vy_r}) + GRAV_W;
      if (vy_sum_s > MAXF_W) begin
         vy_grav_s = MAXF_W[7:0];
      end else begin
         vy_grav_s = vy_sum_s[7:0];
      end
      if (keycode == KEY_A) begin
         nx_s = $signed({1'b0, x_r}) - X_STEP_W;
      end else if (keycode == KEY_D) begin
         nx_s = $signed({1'b0, x_r}) + X_STEP_W;
      end else begin
         nx_s = $signed({1'b0, x_r});
      end
      if (nx_s < SIZE_W) begin
         x_wrap_s = X_WRAP_HI;
      end else if (nx_s > X_LIM_W) begin
         x_wrap_s = SIZE_U;
      end else begin
         x_wrap_s = nx_s[9:0];
      end
   end

   // Ceiling and floor are mutually exclusive with each other and with a
   // bounce (which needs Vy>0), so their order only settles bounce-vs-floor.
   assign ceil_s   = (ny_s < SIZE_W);
   assign bounce_s = (state_r == ST_FALL) && plat_hit && (vy_r > 8'sd0);
   assign floor_s  = (state_r == ST_FALL) && ((ny_s + SIZE_W) > Y_MAX_W);

   // Game-state register.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; only a frame tick can move the state machine.
   always_comb begin
      state_nx_s = state_r;
      if (tick_s) begin
         case (state_r)
            ST_IDLE: begin
               if (keycode == KEY_SPACE) begin
                  state_nx_s = ST_RISE;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end
            ST_RISE, ST_FALL: begin
               if (ceil_s) begin
                  state_nx_s = ST_FALL;
               end else if (bounce_s) begin
                  state_nx_s = ST_RISE;
               end else if (floor_s) begin
                  state_nx_s = ST_DEAD;
               end else if ((state_r == ST_RISE) && !vy_grav_s[7]) begin
                  state_nx_s = ST_FALL;
               end else begin
                  state_nx_s = state_r;
               end
            end
            ST_DEAD: begin
               if (keycode == KEY_ENTER) begin
                  state_nx_s = ST_IDLE;
               end else begin
                  state_nx_s = ST_DEAD;
               end
            end
            default: state_nx_s = ST_IDLE;
         endcase
      end else begin
         state_nx_s = state_r;
      end
   end

   // Datapath next values: position, vertical speed and bounce counter.
   always_comb begin
      x_nx_s       = x_r;
      y_nx_s       = y_r;
      vy_nx_s      = vy_r;
      bounces_nx_s = bounces_r;
      if (tick_s) begin
         case (state_r)
            ST_IDLE: begin
               if (keycode == KEY_SPACE) begin
                  vy_nx_s      = VY_LAUNCH;
                  bounces_nx_s = 8'd0;
               end else begin
                  vy_nx_s = vy_r;
               end
            end
            ST_RISE, ST_FALL: begin
               x_nx_s = x_wrap_s;
               if (ceil_s) begin
                  y_nx_s  = SIZE_U;
                  vy_nx_s = 8'sd0;
               end else if (bounce_s) begin
                  y_nx_s  = ny_s[9:0];
                  vy_nx_s = VY_LAUNCH;
                  if (bounces_r == 8'd255) begin
                     bounces_nx_s = bounces_r;
                  end else begin
                     bounces_nx_s = bounces_r + 8'd1;
                  end
               end else if (floor_s) begin
                  y_nx_s  = Y_REST_U;
                  vy_nx_s = 8'sd0;
               end else begin
                  y_nx_s  = ny_s[9:0];
                  vy_nx_s = vy_grav_s;
               end
            end
            ST_DEAD: begin
               if (keycode == KEY_ENTER) begin
                  x_nx_s  = X_START_U;
                  y_nx_s  = Y_START_U;
                  vy_nx_s = 8'sd0;
               end else begin
                  x_nx_s = x_r;
               end
            end
            default: begin
               x_nx_s  = X_START_U;
               y_nx_s  = Y_START_U;
               vy_nx_s = 8'sd0;
            end
         endcase
      end else begin
         x_nx_s = x_r;
      end
   end

   // Datapath registers.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         x_r       <= X_START_U;
         y_r       <= Y_START_U;
         vy_r      <= 8'sd0;
         bounces_r <= 8'd0;
      end else begin
         x_r       <= x_nx_s;
         y_r       <= y_nx_s;
         vy_r      <= vy_nx_s;
         bounces_r <= bounces_nx_s;
      end
   end

   assign BallX     = x_r;
   assign BallY     = y_r;
   assign Ball_size = SIZE_U;
   assign outstate  = state_r;
   assign Bounces   = bounces_r;

endmodule
